// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS-style control FSM.
// The JUMP state only exists when MC_JUMP_EN is defined.
`timescale 1ns/1ps
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8
`ifdef MC_JUMP_EN
    , JUMP = 4'd9
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select: register B, constant 4, sign-extended imm, imm << 2
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Dispatch out of DECODE; FETCH as the result marks an unsupported opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = MEMADR;
      OP_RTYPE:     nxt = RTEXEC;
      OP_BEQ:       nxt = BRANCH;
      OP_J: begin
`ifdef MC_JUMP_EN
        nxt = JUMP;
`else
        nxt = FETCH;
`endif
      end
      default:      nxt = FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM (fetch/decode/mem/R-type/branch, optional jump).
// Define MC_JUMP_EN to enable the JUMP state for opcode 000010.
`timescale 1ns/1ps
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOP,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t state_reg;
  state_t state_next;
  state_t out_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  state_next = mem_ready ? DECODE : FETCH;
      DECODE: state_next = decode_next(opcode);
      MEMADR: begin
        if (opcode == OP_SW)      state_next = MEMWR;
        else if (opcode == OP_LW) state_next = MEMRD;
        else                      state_next = FETCH;
      end
      MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_next = FETCH;
      MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
      RTEXEC: state_next = RTWB;
      RTWB:   state_next = FETCH;
      BRANCH: state_next = FETCH;
`ifdef MC_JUMP_EN
      JUMP:   state_next = FETCH;
`endif
      default: state_next = FETCH;
    endcase
  end

  // Outputs present FETCH while reset is high, even though the register only
  // moves to FETCH at the next edge.
  assign out_state = reset ? FETCH : state_reg;
  assign state_dbg = out_state;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REG;
    AluOP       = ALUOP_ADD;
    illegal_op  = 1'b0;
    case (out_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        AluOP   = ALUOP_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB    = SRCB_IMM_SH;
        AluOP      = ALUOP_ADD;
        illegal_op = (decode_next(opcode) == FETCH);
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        AluOP   = ALUOP_ADD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        AluOP   = ALUOP_FUNCT;
      end
      RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        AluOP       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
`ifdef MC_JUMP_EN
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table through a
// scoreboard queue, then instruction latency sequences.
`timescale 1ns/1ps
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] PCSource, ALUSrcB, AluOP;
  logic [3:0] state_dbg;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .AluOP(AluOP), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
  //  RegWrite,RegDst, PCSource, ALUSrcB, AluOP, illegal_op}
  logic [16:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, AluOP, illegal_op};

  localparam logic [16:0] C_RST        = 17'b0000000000_00_01_00_0;
  localparam logic [16:0] C_FETCH_RDY  = 17'b1001001000_00_01_00_0;
  localparam logic [16:0] C_FETCH_WAIT = 17'b0001000000_00_01_00_0;
  localparam logic [16:0] C_DECODE     = 17'b0000000000_00_11_00_0;
  localparam logic [16:0] C_DECODE_ILL = 17'b0000000000_00_11_00_1;
  localparam logic [16:0] C_MEMADR     = 17'b0000000100_00_10_00_0;
  localparam logic [16:0] C_MEMRD      = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] C_MEMWB      = 17'b0000010010_00_00_00_0;
  localparam logic [16:0] C_MEMWR      = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] C_RTEXEC     = 17'b0000000100_00_00_10_0;
  localparam logic [16:0] C_RTWB       = 17'b0000000011_00_00_00_0;
  localparam logic [16:0] C_BRANCH     = 17'b0100000100_01_00_01_0;
`ifdef MC_JUMP_EN
  localparam logic [16:0] C_JUMP       = 17'b1000000000_10_00_00_0;
`endif

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [16:0] exp_ctrl;
    string       tag;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    string       tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(input logic rst, input logic [5:0] op, input logic rdy,
                              input state_t st, input logic [16:0] c, input string tag);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy;
    v.exp_state = st; v.exp_ctrl = c; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic latency(input logic [5:0] op, input int want, input string tag);
    int cycles;
    opcode    = op;
    mem_ready = 1'b1;
    checks++;
    if (state_dbg !== FETCH) begin
      errors++;
      $display("FAIL %s start: state_dbg=%0d required=%0d", tag, state_dbg, FETCH);
    end
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (state_dbg !== FETCH && cycles < 16);
    checks++;
    if (cycles != want) begin
      errors++;
      $display("FAIL %s latency: got=%0d required=%0d", tag, cycles, want);
    end else begin
      $display("latency %s: %0d cycles", tag, cycles);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;

    add(1, 6'h3f,    1, FETCH,  C_RST,        "reset_rdy_high");
    add(1, 6'h00,    0, FETCH,  C_RST,        "reset_hold");
    // lw, opcode garbage outside DECODE/MEMADR
    add(0, 6'h15,    1, FETCH,  C_FETCH_RDY,  "lw_fetch");
    add(0, OP_LW,    1, DECODE, C_DECODE,     "lw_decode");
    add(0, OP_LW,    1, MEMADR, C_MEMADR,     "lw_memadr");
    add(0, 6'h3f,    1, MEMRD,  C_MEMRD,      "lw_memrd");
    add(0, OP_SW,    1, MEMWB,  C_MEMWB,      "lw_memwb");
    // R-type
    add(0, 6'h2b,    1, FETCH,  C_FETCH_RDY,  "r_fetch");
    add(0, OP_RTYPE, 1, DECODE, C_DECODE,     "r_decode");
    add(0, OP_BEQ,   1, RTEXEC, C_RTEXEC,     "r_exec");
    add(0, OP_LW,    1, RTWB,   C_RTWB,       "r_wb");
    // sw with three wait cycles
    add(0, 6'h00,    1, FETCH,  C_FETCH_RDY,  "sw_fetch");
    add(0, OP_SW,    1, DECODE, C_DECODE,     "sw_decode");
    add(0, OP_SW,    0, MEMADR, C_MEMADR,     "sw_memadr");
    add(0, 6'h00,    0, MEMWR,  C_MEMWR,      "sw_wait1");
    add(0, 6'h00,    0, MEMWR,  C_MEMWR,      "sw_wait2");
    add(0, 6'h00,    0, MEMWR,  C_MEMWR,      "sw_wait3");
    add(0, 6'h00,    1, MEMWR,  C_MEMWR,      "sw_done");
    // fetch stalls, then beq
    add(0, 6'h00,    0, FETCH,  C_FETCH_WAIT, "fetch_wait1");
    add(0, 6'h00,    0, FETCH,  C_FETCH_WAIT, "fetch_wait2");
    add(0, 6'h00,    1, FETCH,  C_FETCH_RDY,  "fetch_ready");
    add(0, OP_BEQ,   1, DECODE, C_DECODE,     "beq_decode");
    add(0, OP_LW,    0, BRANCH, C_BRANCH,     "beq_branch");
    // illegal opcode
    add(0, 6'h00,    1, FETCH,  C_FETCH_RDY,  "ill_fetch");
    add(0, 6'h3f,    1, DECODE, C_DECODE_ILL, "ill_decode");
    add(0, 6'h00,    1, FETCH,  C_FETCH_RDY,  "j_fetch");
`ifdef MC_JUMP_EN
    add(0, OP_J,     1, DECODE, C_DECODE,     "j_decode");
    add(0, 6'h00,    1, JUMP,   C_JUMP,       "j_jump");
`else
    add(0, OP_J,     1, DECODE, C_DECODE_ILL, "j_decode_ill");
`endif
    // reset during MEMRD wait, then a full lw
    add(0, 6'h00,    1, FETCH,  C_FETCH_RDY,  "rst_rd_fetch");
    add(0, OP_LW,    1, DECODE, C_DECODE,     "rst_rd_decode");
    add(0, OP_LW,    1, MEMADR, C_MEMADR,     "rst_rd_memadr");
    add(0, OP_LW,    0, MEMRD,  C_MEMRD,      "rst_rd_wait");
    add(1, OP_LW,    0, FETCH,  C_RST,        "rst_in_memrd");
    add(0, OP_LW,    1, FETCH,  C_FETCH_RDY,  "post_rst_fetch");
    add(0, OP_LW,    1, DECODE, C_DECODE,     "post_rst_decode");
    add(0, OP_LW,    1, MEMADR, C_MEMADR,     "post_rst_memadr");
    add(0, OP_LW,    1, MEMRD,  C_MEMRD,      "post_rst_memrd");
    add(0, OP_LW,    1, MEMWB,  C_MEMWB,      "post_rst_memwb");
    // reset during MEMWR wait
    add(0, 6'h00,    1, FETCH,  C_FETCH_RDY,  "rst_wr_fetch");
    add(0, OP_SW,    1, DECODE, C_DECODE,     "rst_wr_decode");
    add(0, OP_SW,    1, MEMADR, C_MEMADR,     "rst_wr_memadr");
    add(0, OP_SW,    0, MEMWR,  C_MEMWR,      "rst_wr_wait");
    add(1, OP_SW,    1, FETCH,  C_RST,        "rst_in_memwr");
    add(0, OP_SW,    0, FETCH,  C_FETCH_WAIT, "post_rst_wait");
    add(1, 6'h00,    0, FETCH,  C_RST,        "final_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      reset     = vecs[i].rst;
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      e.st = vecs[i].exp_state; e.ctrl = vecs[i].exp_ctrl; e.tag = vecs[i].tag;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (state_dbg !== e.st || ctrl !== e.ctrl) begin
        errors++;
        $display("FAIL %s: state_dbg=%0d ctrl=%b required state_dbg=%0d ctrl=%b",
                 e.tag, state_dbg, ctrl, e.st, e.ctrl);
      end else begin
        $display("vec %0d %s: state_dbg=%0d ctrl=%b", i, e.tag, state_dbg, ctrl);
      end
    end

    // Leave reset at a posedge so each latency run starts in a FETCH cycle.
    @(posedge clk); #1;
    reset = 1'b0;
    latency(OP_LW,    5, "lw");
    latency(OP_SW,    4, "sw");
    latency(OP_RTYPE, 4, "rtype");
    latency(OP_BEQ,   3, "beq");
`ifdef MC_JUMP_EN
    latency(OP_J,     3, "j");
`else
    latency(OP_J,     2, "j_illegal");
`endif
    latency(6'h3f,    2, "illegal");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
